stack_control_sequencer: RTL and testbench
==========================================

Name: stack_control_sequencer

Overview:
Multi-cycle control FSM for the stack-machine datapath (PC, IR, ValA/ValB, main/return stack pointers, dual-port memory, ALU). Drives every datapath control input, one control word per state. Decodes the opcode from the datapath's IROut and samples isZero for conditional branches. Replaces hand-driven control vectors; sits beside the datapath in the top-level CPU.

Parameters:
OPC_MSB, 15, top bit of the opcode field in IROut
OPC_W, 4, opcode width; opcode = IROut[OPC_MSB -: OPC_W]

Ports:
CLK  in  1  system clock, rising edge
nReset  in  1  asynchronous active-low reset
Run  in  1  level; high allows instruction issue
IROut  in  16  current instruction from the datapath IR
isZero  in  1  ALU zero flag from the datapath
Halted  out  1  high in HALT state
PCWrite, PCSource, PCAdd  out  1 each  PC control
IRWrite, ValAWrite, ValBWrite  out  1 each  register enables
MemRead1, MemRead2, MemWrite1, MemWrite2  out  1 each  memory port strobes
MemDst1, MemDst2  out  2 each  memory address selects
MemData  out  3  write-data select (always 0 in this revision)
MSPWrite, MSPop, RSPWrite, RSPop  out  1 each  stack-pointer control
ResWrite, ResSource  out  1 each  result register control
ALUop  out  4  ALU operation

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC1, EXEC2, HALT. Outputs decode combinationally from state and IROut (Moore per state). The datapath samples them at the rising edge that ends the state.
- Reset (async, nReset=0): state=IDLE; every control output 0; Halted=0. Reset mid-instruction aborts it immediately.
- IDLE: all outputs 0. Goes to FETCH when Run=1.
- FETCH: PCWrite=1, PCSource=0, PCAdd=0, MemRead1=1, MemDst1=00. Always goes to DECODE.
- DECODE: IRWrite=1. Always goes to EXEC1. The opcode becomes valid in EXEC1.
- EXEC1/EXEC2 actions by opcode. Unlisted outputs are 0.
  - 0x0 NOP: EXEC1 no action.
  - 0x1 LDB: EXEC1 MemRead1, MemDst1=01, MSPWrite, MSPop=0; EXEC2 ValBWrite.
  - 0x2 RPOPA: EXEC1 MemRead2, MemDst2=01, RSPWrite, RSPop=1; EXEC2 ValAWrite.
  - 0x3 JPOP: EXEC1 PCWrite, PCSource=1, MemRead2, MemDst2=00, MSPWrite, MSPop=1; EXEC2 ValAWrite.
  - 0x4 LDIND: EXEC1 MemRead1, MemDst1=10, MemRead2, MemDst2=00, MSPWrite, MSPop=0; EXEC2 ValAWrite, ValBWrite.
  - 0x5 BR: EXEC1 PCWrite, PCAdd=1.
  - 0x6 BZ: EXEC1 PCAdd=1; PCWrite=isZero, sampled combinationally during EXEC1.
  - 0x7 ALU: EXEC1 ALUop=IROut[11:8], ResWrite=1, ResSource=0.
  - 0xF HALT: EXEC1 no action, then go to HALT.
  - Any other opcode is illegal and goes to HALT.
- Ops 0x1–0x4 use EXEC2; all others end in EXEC1.
- From the final exec state: go to FETCH if Run=1, else IDLE. Run is sampled only there and in IDLE; deasserting Run never truncates an instruction.
- Latency: single-exec ops take 3 cycles; two-exec ops take 4 cycles.
- HALT: all outputs 0, Halted=1. Only reset leaves HALT.
- No two control words ever assert both MSPWrite and RSPWrite.

Optional Feature:
Macro SEQ_RETIRE_COUNT_EN.
- Defined: adds output RetireCount[15:0]. It resets to 0 and increments by 1 on the final exec cycle of every instruction that is not HALT and not illegal. It wraps 0xFFFF→0x0000.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset with Run=0 for 5 cycles, release -> state IDLE, all outputs 0. Set Run=1 -> next cycle PCWrite=1, MemRead1=1, MemDst1=00, then IRWrite=1.
- IROut=0x1000 (LDB) -> EXEC1 shows MemRead1=1, MemDst1=01, MSPWrite=1, MSPop=0. EXEC2 shows ValBWrite=1. FETCH follows, for 4 cycles total.
- IROut=0x6000 (BZ): isZero=0 -> PCWrite=0 in EXEC1; isZero=1 -> PCWrite=1, PCAdd=1. Both take 3 cycles.
- IROut=0x7A00 (ALU) -> ALUop=0xA, ResWrite=1 for exactly one cycle.
- IROut=0xF000, then IROut=0x9000 after re-reset -> Halted=1 and stays high for 20+ cycles with all controls 0. nReset low clears Halted asynchronously, before the next clock edge.
- Drop Run during EXEC1 of JPOP (0x3000) -> EXEC2 ValAWrite=1 still occurs, then IDLE. With SEQ_RETIRE_COUNT_EN, RetireCount increments by 1.

Source files
------------

// File: rtl/stack_control_sequencer.sv
// stack_control_sequencer: multi-cycle control FSM, one datapath control word per state; SEQ_RETIRE_COUNT_EN adds RetireCount.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC1), 4 for opcodes 0x1-0x4 which also use EXEC2.
// Backpressure: Run is sampled only in IDLE and in the final exec state; an issued instruction always completes.
module stack_control_sequencer #(
    parameter int OPC_MSB = 15,
    parameter int OPC_W   = 4
) (
    input  logic        CLK,
    input  logic        nReset,
    input  logic        Run,
    input  logic [15:0] IROut,
    input  logic        isZero,
    output logic        Halted,
    output logic        PCWrite,
    output logic        PCSource,
    output logic        PCAdd,
    output logic        IRWrite,
    output logic        ValAWrite,
    output logic        ValBWrite,
    output logic        MemRead1,
    output logic        MemRead2,
    output logic        MemWrite1,
    output logic        MemWrite2,
    output logic [1:0]  MemDst1,
    output logic [1:0]  MemDst2,
    output logic [2:0]  MemData,
    output logic        MSPWrite,
    output logic        MSPop,
    output logic        RSPWrite,
    output logic        RSPop,
    output logic        ResWrite,
    output logic        ResSource,
    output logic [3:0]  ALUop
`ifdef SEQ_RETIRE_COUNT_EN
    ,
    output logic [15:0] RetireCount
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC1  = 3'd3,
        EXEC2  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [OPC_W-1:0] OP_LDB   = OPC_W'(4'h1);
    localparam logic [OPC_W-1:0] OP_RPOPA = OPC_W'(4'h2);
    localparam logic [OPC_W-1:0] OP_JPOP  = OPC_W'(4'h3);
    localparam logic [OPC_W-1:0] OP_LDIND = OPC_W'(4'h4);
    localparam logic [OPC_W-1:0] OP_BR    = OPC_W'(4'h5);
    localparam logic [OPC_W-1:0] OP_BZ    = OPC_W'(4'h6);
    localparam logic [OPC_W-1:0] OP_ALU   = OPC_W'(4'h7);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(4'hF);

    state_t           state, nextState;
    logic [OPC_W-1:0] opcode;
    logic             isTwoExec;
    logic             isLegal;
    logic             unusedIrBits;

    assign opcode       = IROut[OPC_MSB -: OPC_W];
    assign isTwoExec    = (opcode >= OP_LDB) && (opcode <= OP_LDIND);
    assign isLegal      = (opcode <= OP_ALU) || (opcode == OP_HALT);
    assign unusedIrBits = ^IROut[7:0];

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        Halted    = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        PCAdd     = 1'b0;
        IRWrite   = 1'b0;
        ValAWrite = 1'b0;
        ValBWrite = 1'b0;
        MemRead1  = 1'b0;
        MemRead2  = 1'b0;
        MemWrite1 = 1'b0;
        MemWrite2 = 1'b0;
        MemDst1   = 2'b00;
        MemDst2   = 2'b00;
        MemData   = 3'b000;
        MSPWrite  = 1'b0;
        MSPop     = 1'b0;
        RSPWrite  = 1'b0;
        RSPop     = 1'b0;
        ResWrite  = 1'b0;
        ResSource = 1'b0;
        ALUop     = 4'h0;

        case (state)
            IDLE: begin
                if (Run) nextState = FETCH;
            end
            FETCH: begin
                PCWrite   = 1'b1;
                MemRead1  = 1'b1;
                nextState = DECODE;
            end
            DECODE: begin
                IRWrite   = 1'b1;
                nextState = EXEC1;
            end
            EXEC1: begin
                case (opcode)
                    OP_LDB: begin
                        MemRead1 = 1'b1;
                        MemDst1  = 2'b01;
                        MSPWrite = 1'b1;
                    end
                    OP_RPOPA: begin
                        MemRead2 = 1'b1;
                        MemDst2  = 2'b01;
                        RSPWrite = 1'b1;
                        RSPop    = 1'b1;
                    end
                    OP_JPOP: begin
                        PCWrite  = 1'b1;
                        PCSource = 1'b1;
                        MemRead2 = 1'b1;
                        MSPWrite = 1'b1;
                        MSPop    = 1'b1;
                    end
                    OP_LDIND: begin
                        MemRead1 = 1'b1;
                        MemDst1  = 2'b10;
                        MemRead2 = 1'b1;
                        MSPWrite = 1'b1;
                    end
                    OP_BR: begin
                        PCWrite = 1'b1;
                        PCAdd   = 1'b1;
                    end
                    OP_BZ: begin
                        PCWrite = isZero;
                        PCAdd   = 1'b1;
                    end
                    OP_ALU: begin
                        ALUop    = IROut[11:8];
                        ResWrite = 1'b1;
                    end
                    default: ;
                endcase
                // HALT and illegal opcodes both park the machine until reset
                if (!isLegal || (opcode == OP_HALT)) nextState = HALT;
                else if (isTwoExec)                  nextState = EXEC2;
                else                                 nextState = Run ? FETCH : IDLE;
            end
            EXEC2: begin
                ValAWrite = (opcode == OP_RPOPA) || (opcode == OP_JPOP) || (opcode == OP_LDIND);
                ValBWrite = (opcode == OP_LDB) || (opcode == OP_LDIND);
                nextState = Run ? FETCH : IDLE;
            end
            HALT: begin
                Halted = 1'b1;
            end
            default: nextState = IDLE;
        endcase
    end

`ifdef SEQ_RETIRE_COUNT_EN
    logic retire;
    assign retire = (state == EXEC2) ||
                    ((state == EXEC1) && isLegal && (opcode != OP_HALT) && !isTwoExec);

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            RetireCount <= 16'h0000;
        end else if (retire) begin
            RetireCount <= RetireCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_control_sequencer.sv
// Directed bench for stack_control_sequencer: an instruction-level model predicts every control word each cycle.
module tb_stack_control_sequencer;

    logic        CLK = 1'b0;
    logic        nReset, Run, isZero;
    logic [15:0] IROut;
    logic        Halted, PCWrite, PCSource, PCAdd, IRWrite, ValAWrite, ValBWrite;
    logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
    logic [1:0]  MemDst1, MemDst2;
    logic [2:0]  MemData;
    logic        MSPWrite, MSPop, RSPWrite, RSPop, ResWrite, ResSource;
    logic [3:0]  ALUop;
`ifdef SEQ_RETIRE_COUNT_EN
    logic [15:0] RetireCount;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    stack_control_sequencer dut (
        .CLK(CLK), .nReset(nReset), .Run(Run), .IROut(IROut), .isZero(isZero),
        .Halted(Halted), .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
        .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite),
        .MemRead1(MemRead1), .MemRead2(MemRead2), .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
        .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
        .MSPWrite(MSPWrite), .MSPop(MSPop), .RSPWrite(RSPWrite), .RSPop(RSPop),
        .ResWrite(ResWrite), .ResSource(ResSource), .ALUop(ALUop)
`ifdef SEQ_RETIRE_COUNT_EN
        , .RetireCount(RetireCount)
`endif
    );

    typedef struct packed {
        logic       halted, pcWrite, pcSource, pcAdd, irWrite, valAWrite, valBWrite;
        logic       memRead1, memRead2, memWrite1, memWrite2;
        logic [1:0] memDst1, memDst2;
        logic [2:0] memData;
        logic       mspWrite, msPop, rspWrite, rsPop, resWrite, resSource;
        logic [3:0] aluOp;
    } cw_t;

    cw_t dutWord, expWord;
    assign dutWord = {Halted, PCWrite, PCSource, PCAdd, IRWrite, ValAWrite, ValBWrite,
                      MemRead1, MemRead2, MemWrite1, MemWrite2, MemDst1, MemDst2, MemData,
                      MSPWrite, MSPop, RSPWrite, RSPop, ResWrite, ResSource, ALUop};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Number of exec cycles an opcode needs
    function automatic int execLen(logic [3:0] op);
        return (op >= 4'h1 && op <= 4'h4) ? 2 : 1;
    endfunction

    // mode: 0 idle, 1 running, 2 halted; pos: 0 fetch, 1 decode, 2 exec1, 3 exec2
    function automatic cw_t expectWord(int mode, int pos, logic [15:0] ir, logic z);
        cw_t w;
        logic [3:0] op;
        w  = '0;
        op = ir[15:12];
        if (mode == 2) begin
            w.halted = 1'b1;
        end else if (mode == 1) begin
            if (pos == 0) begin
                w.pcWrite  = 1'b1;
                w.memRead1 = 1'b1;
            end else if (pos == 1) begin
                w.irWrite = 1'b1;
            end else if (pos == 2) begin
                case (op)
                    4'h1: begin w.memRead1 = 1'b1; w.memDst1 = 2'b01; w.mspWrite = 1'b1; end
                    4'h2: begin w.memRead2 = 1'b1; w.memDst2 = 2'b01; w.rspWrite = 1'b1; w.rsPop = 1'b1; end
                    4'h3: begin w.pcWrite = 1'b1; w.pcSource = 1'b1; w.memRead2 = 1'b1;
                                w.mspWrite = 1'b1; w.msPop = 1'b1; end
                    4'h4: begin w.memRead1 = 1'b1; w.memDst1 = 2'b10; w.memRead2 = 1'b1; w.mspWrite = 1'b1; end
                    4'h5: begin w.pcWrite = 1'b1; w.pcAdd = 1'b1; end
                    4'h6: begin w.pcWrite = z; w.pcAdd = 1'b1; end
                    4'h7: begin w.aluOp = ir[11:8]; w.resWrite = 1'b1; end
                    default: ;
                endcase
            end else begin
                w.valAWrite = (op == 4'h2) || (op == 4'h3) || (op == 4'h4);
                w.valBWrite = (op == 4'h1) || (op == 4'h4);
            end
        end
        return w;
    endfunction

    int          mMode, mPos;
    logic [15:0] mCount;

    always @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            mMode  <= 0;
            mPos   <= 0;
            mCount <= 16'h0000;
        end else if (mMode == 0) begin
            if (Run) begin
                mMode <= 1;
                mPos  <= 0;
            end
        end else if (mMode == 1) begin
            if (mPos < 1 + execLen(IROut[15:12])) begin
                mPos <= mPos + 1;
            end else if (IROut[15:12] > 4'h7) begin
                mMode <= 2;
            end else begin
                mCount <= mCount + 16'd1;
                if (Run) mPos <= 0;
                else     mMode <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        expWord = expectWord(mMode, mPos, IROut, isZero);
        check("ctrlWord", 32'(dutWord), 32'(expWord));
        if (MSPWrite && RSPWrite) check("spExclusive", 32'(1), 32'(0));
`ifdef SEQ_RETIRE_COUNT_EN
        check("retireModel", 32'(RetireCount), 32'(mCount));
`endif
    end

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    logic [15:0] ops [6] = '{16'h0000, 16'h2000, 16'h4000, 16'h5000, 16'h7300, 16'h1000};

    initial begin
        nReset = 1'b0;
        Run    = 1'b0;
        isZero = 1'b0;
        IROut  = 16'h0000;
        repeat (5) cyc();
        nReset = 1'b1;
        cyc();
        check("idleHalted", 32'(Halted), 32'(0));
        check("idleWord", 32'(dutWord), 32'(0));

        IROut = 16'h1000;
        Run   = 1'b1;
        cyc(); check("fetchPC", 32'(PCWrite), 32'(1));
               check("fetchMem", 32'({MemRead1, MemDst1}), 32'(3'b100));
        cyc(); check("decodeIR", 32'(IRWrite), 32'(1));
        cyc(); check("ldbExec1", 32'({MemRead1, MemDst1, MSPWrite, MSPop}), 32'(5'b10110));
        cyc(); check("ldbExec2", 32'(ValBWrite), 32'(1));
        cyc(); check("ldbRefetch", 32'(PCWrite), 32'(1));

        IROut  = 16'h6000;
        isZero = 1'b0;
        cyc(); cyc(); check("bzNotTaken", 32'({PCWrite, PCAdd}), 32'(2'b01));
        cyc(); check("bzLen3", 32'({PCWrite, MemRead1}), 32'(2'b11));
        isZero = 1'b1;
        cyc(); cyc(); check("bzTaken", 32'({PCWrite, PCAdd}), 32'(2'b11));
        cyc();
        IROut = 16'h7A00;
        cyc(); cyc(); check("aluExec", 32'({ALUop, ResWrite}), 32'(5'b10101));
        cyc(); check("aluOneCycle", 32'(ResWrite), 32'(0));

        IROut = 16'h3000;
        cyc(); cyc(); check("jpopExec1", 32'({PCWrite, PCSource, MemRead2, MSPWrite, MSPop}), 32'(5'b11111));
        Run = 1'b0;
        cyc(); check("jpopExec2", 32'(ValAWrite), 32'(1));
        cyc(); check("jpopIdle", 32'(dutWord), 32'(0));
        cyc(); check("stillIdle", 32'(dutWord), 32'(0));
`ifdef SEQ_RETIRE_COUNT_EN
        check("retire5", 32'(RetireCount), 32'(5));
`endif

        Run = 1'b1;
        cyc();
        for (int i = 0; i < 6; i++) begin
            IROut = ops[i];
            repeat (2 + execLen(ops[i][15:12])) cyc();
        end

        IROut = 16'hF000;
        cyc(); cyc(); check("haltExec1", 32'(dutWord), 32'(0));
        cyc(); check("haltState", 32'(Halted), 32'(1));
        repeat (20) cyc();
        check("haltStays", 32'(dutWord), 32'h0800_0000);
`ifdef SEQ_RETIRE_COUNT_EN
        check("retire11", 32'(RetireCount), 32'(11));
`endif
        nReset = 1'b0;
        #1;
        check("asyncClear", 32'(Halted), 32'(0));
        cyc();

        nReset = 1'b1;
        IROut  = 16'h9000;
        cyc(); cyc(); cyc();
        cyc(); check("illegalHalt", 32'(Halted), 32'(1));
        repeat (20) cyc();
        check("illegalStays", 32'(dutWord), 32'h0800_0000);
`ifdef SEQ_RETIRE_COUNT_EN
        check("retireIllegal", 32'(RetireCount), 32'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
